// File: rtl/fu_alu_stage.sv
// Memory-mapped ALU functional unit: single-cycle logic ops, iterative MUL/DIVU/REMU.
// Define FU_DIV_EN to build the restoring divider; otherwise opcodes 8/9 report invalid.
module fu_alu_stage #(
  parameter int DBITS     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [70:0]       from_DE_to_FU,
  output logic [DBITS+2:0]  from_FU_to_DE
);

  localparam int            STEPS    = DBITS / STEP_BITS;
  localparam int            CW       = $clog2(STEPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
`ifdef FU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd8;
  localparam logic [3:0] OP_REMU = 4'd9;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic [DBITS-1:0] op1_r, op2_r, op3_r;
  logic [3:0]       aluop_r;
  logic             err_r, err_pend_r, busy_r, done_r, iter_r;
  logic [CW-1:0]    cnt_r;
  logic [DBITS-1:0] acc_r, a_r, b_r;

  logic             wr_aluop_s, wr_op1_s, wr_op2_s, rd_op3_s;
  logic [DBITS-1:0] data_s;
  logic             unused_bus_s;
  logic             accept_s, is_mul_s, is_div_s, divz_s, iter_op_s, last_s, finish_s;
  logic [DBITS-1:0] res_s, iter_res_s;
  logic             op_err_s;
  logic [DBITS-1:0] acc_nx_s, a_nx_s, b_nx_s;
`ifdef FU_DIV_EN
  logic [DBITS:0]   rem_s;
`endif

  assign wr_aluop_s   = from_DE_to_FU[0];
  assign wr_op1_s     = from_DE_to_FU[1];
  assign wr_op2_s     = from_DE_to_FU[2];
  assign data_s       = from_DE_to_FU[3 +: DBITS];
  assign rd_op3_s     = from_DE_to_FU[35];
  assign unused_bus_s = ^from_DE_to_FU[70:36];

  assign from_FU_to_DE = {err_r, done_r, busy_r, op3_r};

  assign is_mul_s = (aluop_r == OP_MUL);
`ifdef FU_DIV_EN
  assign is_div_s = (aluop_r == OP_DIVU) || (aluop_r == OP_REMU);
`else
  assign is_div_s = 1'b0;
`endif
  assign divz_s    = is_div_s && (op2_r == {DBITS{1'b0}});
  assign iter_op_s = is_mul_s || (is_div_s && !divz_s);
  assign accept_s  = wr_aluop_s && (state_r != S_BUSY);
  assign last_s    = iter_r && (cnt_r == CNT_LAST);
  assign finish_s  = (state_r == S_BUSY) && ((!iter_r && !iter_op_s) || last_s);

  // Single-cycle results, including the divide-by-zero shortcut and invalid opcodes
  always_comb begin
    res_s    = {DBITS{1'b0}};
    op_err_s = 1'b0;
    case (aluop_r)
      OP_ADD:  res_s = op1_r + op2_r;
      OP_SUB:  res_s = op1_r - op2_r;
      OP_AND:  res_s = op1_r & op2_r;
      OP_OR:   res_s = op1_r | op2_r;
      OP_XOR:  res_s = op1_r ^ op2_r;
      OP_SLL:  res_s = op1_r << op2_r[4:0];
      OP_SRL:  res_s = op1_r >> op2_r[4:0];
      OP_MUL:  res_s = {DBITS{1'b0}};
`ifdef FU_DIV_EN
      OP_DIVU: begin res_s = {DBITS{1'b1}}; op_err_s = divz_s; end
      OP_REMU: begin res_s = op1_r;         op_err_s = divz_s; end
`endif
      default: begin res_s = {DBITS{1'b0}}; op_err_s = 1'b1; end
    endcase
  end

  // One iteration: STEP_BITS shift-add multiply or restoring-division steps
  always_comb begin
    acc_nx_s = acc_r;
    a_nx_s   = a_r;
    b_nx_s   = b_r;
`ifdef FU_DIV_EN
    rem_s    = {(DBITS + 1){1'b0}};
`endif
    for (int i = 0; i < STEP_BITS; i++) begin
      if (is_mul_s) begin
        if (b_nx_s[0]) begin
          acc_nx_s = acc_nx_s + a_nx_s;
        end else begin
          acc_nx_s = acc_nx_s;
        end
        a_nx_s = a_nx_s << 1'b1;
        b_nx_s = b_nx_s >> 1'b1;
      end else begin
`ifdef FU_DIV_EN
        // acc holds the partial remainder, a shifts dividend bits out and quotient bits in
        rem_s  = {acc_nx_s, a_nx_s[DBITS-1]};
        a_nx_s = a_nx_s << 1'b1;
        if (rem_s >= {1'b0, b_nx_s}) begin
          rem_s     = rem_s - {1'b0, b_nx_s};
          a_nx_s[0] = 1'b1;
        end else begin
          a_nx_s[0] = 1'b0;
        end
        acc_nx_s = rem_s[DBITS-1:0];
`else
        acc_nx_s = acc_nx_s;
`endif
      end
    end
  end

  // Final value of an iterative op: product/remainder in acc, quotient in a
  always_comb begin
    iter_res_s = acc_nx_s;
`ifdef FU_DIV_EN
    if (aluop_r == OP_DIVU) begin
      iter_res_s = a_nx_s;
    end else begin
      iter_res_s = acc_nx_s;
    end
`endif
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nx_s = S_BUSY;
        else          state_nx_s = S_IDLE;
      end
      S_BUSY: begin
        if (finish_s) state_nx_s = S_DONE;
        else          state_nx_s = S_BUSY;
      end
      S_DONE: begin
        if (accept_s)      state_nx_s = S_BUSY;
        else if (rd_op3_s) state_nx_s = S_IDLE;
        else               state_nx_s = S_DONE;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_nx_s;
  end

  // Operand, result, status and iteration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op1_r      <= {DBITS{1'b0}};
      op2_r      <= {DBITS{1'b0}};
      op3_r      <= {DBITS{1'b0}};
      aluop_r    <= 4'd0;
      err_r      <= 1'b0;
      err_pend_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      iter_r     <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      acc_r      <= {DBITS{1'b0}};
      a_r        <= {DBITS{1'b0}};
      b_r        <= {DBITS{1'b0}};
    end else begin
      busy_r <= (state_nx_s == S_BUSY);
      done_r <= (state_nx_s == S_DONE);
      if (state_r != S_BUSY) begin
        if (wr_op1_s) op1_r <= data_s;
        if (wr_op2_s) op2_r <= data_s;
        if (accept_s) begin
          aluop_r    <= data_s[3:0];
          err_r      <= 1'b0;
          err_pend_r <= 1'b0;
          iter_r     <= 1'b0;
        end
      end else if (!iter_r) begin
        if (iter_op_s) begin
          iter_r     <= 1'b1;
          cnt_r      <= {CW{1'b0}};
          acc_r      <= {DBITS{1'b0}};
          a_r        <= op1_r;
          b_r        <= op2_r;
          err_pend_r <= err_pend_r | wr_aluop_s;
        end else begin
          op3_r      <= res_s;
          err_r      <= err_pend_r | wr_aluop_s | op_err_s;
          err_pend_r <= 1'b0;
        end
      end else begin
        acc_r <= acc_nx_s;
        a_r   <= a_nx_s;
        b_r   <= b_nx_s;
        cnt_r <= cnt_r + CW'(1'b1);
        if (last_s) begin
          op3_r      <= iter_res_s;
          err_r      <= err_pend_r | wr_aluop_s;
          err_pend_r <= 1'b0;
          iter_r     <= 1'b0;
        end else begin
          err_pend_r <= err_pend_r | wr_aluop_s;
        end
      end
    end
  end

endmodule
